// File: rtl/charge_scatter_weigher_if.sv
// Shared particle/scatter types and the stream bundle between particle store and grid banks.
// Slave modport is the weigher's view; master is the producer/consumer side.
package defs;
  localparam int unsigned NUM_ROWS       = 64;
  localparam int unsigned NUM_COLS       = 64;
  localparam int unsigned GRID_ADDRWIDTH = 12;
  localparam int unsigned CINT           = 12;
  localparam int unsigned CFRAC          = 24;

  typedef logic [CINT+CFRAC-1:0] charge_t;

  typedef struct packed {
    logic [5:0]  whole;
    logic [11:0] fraction;
  } fixed_t;

  typedef struct packed {
    fixed_t y;
    fixed_t x;
  } pos_t;

  typedef struct packed {
    pos_t        pos;
    logic [15:0] vperp;
  } particle_t;

  localparam int unsigned PSIZE = $bits(particle_t);

  typedef struct packed {
    logic [GRID_ADDRWIDTH-3:0] addr;
    charge_t                   weight;
  } scatter_t;
endpackage

interface charge_scatter_weigher_if;
  import defs::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [PSIZE-1:0]              in_particle;
  logic                          out_valid;
  logic                          out_ready;
  logic [4*$bits(scatter_t)-1:0] out_scatter;

  modport slave (
    input  in_valid, in_particle, out_ready,
    output in_ready, out_valid, out_scatter
  );

  modport master (
    output in_valid, in_particle, out_ready,
    input  in_ready, out_valid, out_scatter
  );
endinterface

// File: rtl/charge_scatter_weigher.sv
// Three-stage cloud-in-cell weigher: one particle in, four bank-steered weighted corners out.
// Optional SCATTER_STATS_EN adds stats_clr and a 32-bit particle_count of delivered beats.
module charge_scatter_weigher
  import defs::*;
#(
  parameter int unsigned NROWS   = defs::NUM_ROWS,
  parameter int unsigned NCOLS   = defs::NUM_COLS,
  parameter int unsigned LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef SCATTER_STATS_EN
  input  logic                    stats_clr,
  output logic [31:0]             particle_count,
`endif
  charge_scatter_weigher_if.slave bus
);

  localparam int unsigned CoordBits  = $clog2(NROWS);
  localparam int unsigned FracBits   = 12;
  localparam int unsigned ProdBits   = 2 * FracBits + 2;
  localparam int unsigned AddrBits   = GRID_ADDRWIDTH - 2;
  localparam int unsigned ChargeBits = $bits(charge_t);
  localparam int unsigned ScatBits   = $bits(scatter_t);

  if (NCOLS != NROWS || LATENCY != 3) begin : g_param_check
    $error("charge_scatter_weigher: square grid and fixed 3-cycle pipeline only");
  end

  particle_t p;
  logic      en;
  logic      unused_vperp;

  assign p            = particle_t'(bus.in_particle);
  assign unused_vperp = ^p.vperp;

  logic                 out_valid_q;
  logic [4*ScatBits-1:0] scat_q, scat_d;

  // Single global enable: the whole pipe advances only when the output slot can move.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // S1: corner coordinates (with periodic +1) and 13-bit complements.
  logic                 v1_q;
  logic [CoordBits-1:0] y0_q, y1_q, x0_q, x1_q;
  logic [FracBits-1:0]  fy_q, fx_q;
  logic [FracBits:0]    gy_q, gx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      y0_q <= '0;
      y1_q <= '0;
      x0_q <= '0;
      x1_q <= '0;
      fy_q <= '0;
      fx_q <= '0;
      gy_q <= '0;
      gx_q <= '0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        y0_q <= p.pos.y.whole;
        y1_q <= p.pos.y.whole + 1'b1;
        x0_q <= p.pos.x.whole;
        x1_q <= p.pos.x.whole + 1'b1;
        fy_q <= p.pos.y.fraction;
        fx_q <= p.pos.x.fraction;
        gy_q <= 13'd4096 - {1'b0, p.pos.y.fraction};
        gx_q <= 13'd4096 - {1'b0, p.pos.x.fraction};
      end
    end
  end

  // S2: products indexed {y+1?, x+1?}; each bank picks the corner whose parity matches it.
  logic [ProdBits-1:0]  prod   [4];
  logic [1:0]           sel    [4];
  logic [CoordBits-1:0] row    [4];
  logic [CoordBits-1:0] col    [4];
  logic [AddrBits-1:0]  addr_d [4];
  logic [ProdBits-1:0]  wgt_d  [4];

  always_comb begin
    prod[0] = ProdBits'(gy_q) * ProdBits'(gx_q);
    prod[1] = ProdBits'(gy_q) * ProdBits'(fx_q);
    prod[2] = ProdBits'(fy_q) * ProdBits'(gx_q);
    prod[3] = ProdBits'(fy_q) * ProdBits'(fx_q);
    for (int b = 0; b < 4; b++) begin
      sel[b]    = {y0_q[0] ^ b[1], x0_q[0] ^ b[0]};
      row[b]    = sel[b][1] ? y1_q : y0_q;
      col[b]    = sel[b][0] ? x1_q : x0_q;
      addr_d[b] = {row[b][CoordBits-1:1], col[b][CoordBits-1:1]};
      wgt_d[b]  = prod[sel[b]];
    end
  end

  logic                v2_q;
  logic [AddrBits-1:0] addr2_q [4];
  logic [ProdBits-1:0] wgt2_q  [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        addr2_q[b] <= '0;
        wgt2_q[b]  <= '0;
      end
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        for (int b = 0; b < 4; b++) begin
          addr2_q[b] <= addr_d[b];
          wgt2_q[b]  <= wgt_d[b];
        end
      end
    end
  end

  // S3: pack bank b into slice b of the output beat.
  always_comb begin
    scat_d = '0;
    for (int b = 0; b < 4; b++) begin
      scat_d[ScatBits*b +: ScatBits] = {addr2_q[b], {(ChargeBits-ProdBits){1'b0}}, wgt2_q[b]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      scat_q      <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        scat_q <= scat_d;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_scatter = scat_q;

`ifdef SCATTER_STATS_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (stats_clr) begin
      count_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign particle_count = count_q;
`endif

endmodule

// File: tb/tb_charge_scatter_weigher.sv
// Directed and streamed checks of charge_scatter_weigher against hand values and a corner model.
module tb_charge_scatter_weigher;
  import defs::*;

  localparam int SB = 46;
  localparam int BW = 4 * SB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  charge_scatter_weigher_if bus ();

`ifdef SCATTER_STATS_EN
  logic        stats_clr;
  logic [31:0] particle_count;
`endif

  charge_scatter_weigher dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef SCATTER_STATS_EN
    .stats_clr      (stats_clr),
    .particle_count (particle_count),
`endif
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [PSIZE-1:0] mk(input logic [5:0] yw, input logic [11:0] yf,
                                          input logic [5:0] xw, input logic [11:0] xf);
    return {yw, yf, xw, xf, 16'hA5C3};
  endfunction

  // Scatter each corner into the bank its parity selects.
  function automatic logic [BW-1:0] model(input logic [PSIZE-1:0] pv);
    particle_t   q;
    logic [12:0] ay [2];
    logic [12:0] ax [2];
    logic [BW-1:0] res;
    q     = particle_t'(pv);
    ay[0] = 13'd4096 - {1'b0, q.pos.y.fraction};
    ay[1] = {1'b0, q.pos.y.fraction};
    ax[0] = 13'd4096 - {1'b0, q.pos.x.fraction};
    ax[1] = {1'b0, q.pos.x.fraction};
    res   = '0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        logic [5:0]  gy;
        logic [5:0]  gx;
        logic [25:0] w;
        int          b;
        gy = q.pos.y.whole + 6'(dy);
        gx = q.pos.x.whole + 6'(dx);
        w  = 26'(ay[dy]) * 26'(ax[dx]);
        b  = int'({gy[0], gx[0]});
        res[SB*b +: SB] = {gy[5:1], gx[5:1], 10'd0, w};
      end
    end
    return res;
  endfunction

  task automatic send_one(input logic [PSIZE-1:0] pv, output int lat, output logic [BW-1:0] beat);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_particle = pv;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    beat = bus.out_scatter;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_scatter !== '0) begin
      errors++;
      $display("FAIL reset_out_scatter got %h want 0", bus.out_scatter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_out_valid got %b want 0", bus.out_valid);
      end
    end
  endtask

  // Table rows: aligned point, half-cell point, double wrap at the grid corner.
  task automatic test_corner_vectors;
    logic [PSIZE-1:0]  vp [3];
    logic [3:0][9:0]   va [3];
    logic [3:0][35:0]  vw [3];
    string             nm [3];
    int                lat;
    logic [BW-1:0]     beat;
    vp[0] = mk(6'd7, 12'h000, 6'd5, 12'h000);
    va[0] = {10'd98, 10'd99, 10'd130, 10'd131};
    vw[0] = {36'h001000000, 36'h0, 36'h0, 36'h0};
    nm[0] = "aligned";
    vp[1] = mk(6'd20, 12'h800, 6'd10, 12'h800);
    va[1] = {10'd325, 10'd325, 10'd325, 10'd325};
    vw[1] = {36'h000400000, 36'h000400000, 36'h000400000, 36'h000400000};
    nm[1] = "half";
    vp[2] = mk(6'd63, 12'hC00, 6'd63, 12'h400);
    va[2] = {10'd1023, 10'd992, 10'd31, 10'd0};
    vw[2] = {36'h000300000, 36'h000100000, 36'h000900000, 36'h000300000};
    nm[2] = "wrap";
    for (int v = 0; v < 3; v++) begin
      send_one(vp[v], lat, beat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL %s_latency got %0d want 3", nm[v], lat);
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (beat[SB*b+36 +: 10] !== va[v][b]) begin
          errors++;
          $display("FAIL %s_bank%0d_addr got %0d want %0d", nm[v], b, beat[SB*b+36 +: 10],
                   va[v][b]);
        end
        checks++;
        if (beat[SB*b +: 36] !== vw[v][b]) begin
          errors++;
          $display("FAIL %s_bank%0d_weight got %h want %h", nm[v], b, beat[SB*b +: 36],
                   vw[v][b]);
        end
      end
    end
  endtask

  task automatic test_stream;
    logic [BW-1:0]    expq [$];
    logic [BW-1:0]    exp_beat;
    logic [BW-1:0]    held;
    logic [PSIZE-1:0] pv;
    logic             stalled;
    int               sent;
    int               got;
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    held    = '0;
    pv      = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 16 && $urandom_range(0, 3) != 0) begin
        pv = mk(6'($urandom), 12'($urandom), 6'($urandom), 12'($urandom));
        bus.in_valid    = 1'b1;
        bus.in_particle = pv;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++;
        $display("FAIL stream_in_ready got %b want %b", bus.in_ready,
                 !bus.out_valid || bus.out_ready);
      end
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_scatter !== held) begin
          errors++;
          $display("FAIL stream_stall_hold got %b/%h want 1/%h", bus.out_valid,
                   bus.out_scatter, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stream_extra_beat got %h want none", bus.out_scatter);
        end else begin
          exp_beat = expq.pop_front();
          if (bus.out_scatter !== exp_beat) begin
            errors++;
            $display("FAIL stream_beat%0d got %h want %h", got, bus.out_scatter, exp_beat);
          end
        end
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_scatter;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(pv));
        sent++;
      end
    end
    checks++;
    if (got != 16 || expq.size() != 0) begin
      errors++;
      $display("FAIL stream_count got %0d beats want 16 (pending %0d)", got, expq.size());
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream;
    logic [PSIZE-1:0] pv;
    int               lat;
    logic [BW-1:0]    beat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_particle = mk(6'(i + 1), 12'h123, 6'(i + 9), 12'h456);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_out_valid got %b want 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_scatter !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b/%h want 0/0", bus.out_valid, bus.out_scatter);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_beat got out_valid %b want 0", bus.out_valid);
      end
    end
    pv = mk(6'd33, 12'h0F0, 6'd2, 12'hF0F);
    send_one(pv, lat, beat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL post_reset_latency got %0d want 3", lat);
    end
    checks++;
    if (beat !== model(pv)) begin
      errors++;
      $display("FAIL post_reset_beat got %h want %h", beat, model(pv));
    end
  endtask

`ifdef SCATTER_STATS_EN
  task automatic test_stats;
    int            lat;
    logic [BW-1:0] beat;
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if (particle_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_clear got %0d want 0", particle_count);
    end
    for (int i = 0; i < 10; i++) begin
      send_one(mk(6'(i), 12'h111, 6'(i), 12'h222), lat, beat);
    end
    @(negedge clk);
    checks++;
    if (particle_count !== 32'd10) begin
      errors++;
      $display("FAIL stats_count got %0d want 10", particle_count);
    end
    send_one(mk(6'd4, 12'h0, 6'd4, 12'h0), lat, beat);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if (particle_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_clr_wins got %0d want 0", particle_count);
    end
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_particle = '0;
    bus.out_ready   = 1'b0;
`ifdef SCATTER_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_corner_vectors();
    test_stream();
    test_reset_midstream();
`ifdef SCATTER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
